eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Round-robin scheduler that shares the single 32-bit Ethernet TX stream between several frame generators, such as the ping responder, the ARP responder and the UDP data sender. Each generator raises a level request. The arbiter picks one, fires its one-cycle start strobe, and muxes that generator's stream onto the MAC-side port until the end-of-packet beat is accepted. It then inserts an inter-frame gap. The block sits between the protocol frame builders and the MAC TX FIFO.

## Interface
Parameters:
- NUM_SRC, 3: number of requesting generators (2..8); source 0 is the ping responder.
- IFG_CYCLES, 2: idle cycles forced after each frame (0..15).
- WDT_CYCLES, 1024: stall limit in cycles; used only with the watchdog compiled in.

Ports:
- clk  in  1: single clock, all logic rising-edge.
- rst  in  1: reset, asynchronous, active-high.
- i_req  in  NUM_SRC: level, source n has a frame pending.
- i_src_ready  in  NUM_SRC: source n idle and able to accept a start strobe.
- o_sync  out  NUM_SRC: one-cycle start pulse to the granted source.
- i_src_data  in  32*NUM_SRC: source n data occupies bits [32n+31:32n].
- i_src_sop, i_src_eop, i_src_vld  in  NUM_SRC each: per-source stream flags.
- o_src_rdy  out  NUM_SRC: backpressure to each source; only the granted bit can be 1.
- o_eth_data  out  32: muxed stream to the MAC.
- o_eth_sop, o_eth_eop, o_eth_vld  out  1 each: muxed stream flags.
- i_eth_rdy  in  1: MAC accepts a beat when o_eth_vld and i_eth_rdy are both 1.
- o_grant  out  NUM_SRC: one-hot current owner; 0 when idle.
- o_busy  out  1: 1 in every state except IDLE.
- o_abort  out  1: one-cycle pulse when a frame is killed by the watchdog.

## Operation
States:
- IDLE: eligible sources are i_req & i_src_ready. If any source is eligible, grant the first one searching upward (with wrap) from ptr+1, register o_grant, and go to SYNC.
- SYNC: o_sync[g] = 1 for exactly this cycle, then go to XFER.
- XFER: combinational mux of the granted source. o_eth_vld = i_src_vld[g]. o_eth_data, o_eth_sop and o_eth_eop are taken from source g. o_src_rdy[g] = i_eth_rdy. When an eop beat is accepted: set ptr = g, clear o_grant, load the gap counter, go to GAP.
- GAP: count down IFG_CYCLES, then go to IDLE. If IFG_CYCLES = 0, go straight to IDLE on the next cycle.

Rules:
- The round-robin pointer updates only on a completed or aborted frame.
- After reset, ptr = NUM_SRC-1, so source 0 has first priority.
- sop/eop are passed through unmodified; the arbiter tracks only the accepted eop.
- A request that drops during SYNC or XFER is ignored; the grant holds until eop.
- i_req or i_src_vld on ungranted sources has no effect; their o_src_rdy stays 0.
- When not in XFER: o_eth_vld = 0, o_eth_data = 0, sop/eop = 0.

## Timing
- Reset values: o_sync = 0, o_grant = 0, o_src_rdy = 0, o_eth_vld/sop/eop = 0, o_eth_data = 0, o_busy = 0, o_abort = 0; state IDLE.
- Eligible request sampled at edge t → o_grant valid and state SYNC from t+1 → o_sync high during cycle t+1 → XFER from t+2. The earliest first beat on o_eth_* is in cycle t+2.
- Stream path in XFER is zero-latency combinational, source to MAC and MAC to source.
- Accepted eop at edge e → GAP from e+1. A new grant is decided no earlier than e+1+IFG_CYCLES.
- Minimum frame-to-frame spacing: 2 + IFG_CYCLES cycles of overhead.
- Reset asserted mid-frame → everything returns to reset values immediately. The partial frame is not terminated; the MAC must flush on rst.

## Configuration
- ETH_TX_ARB_WDT_EN defined: in XFER, a counter clears on every accepted beat and otherwise increments.
  - On reaching WDT_CYCLES-1: pulse o_abort for 1 cycle, drop o_src_rdy and o_grant, set ptr = g, go to GAP.
  - The MAC discards the partial frame on o_abort.
- ETH_TX_ARB_WDT_EN undefined: no counter; o_abort tied to 0; XFER waits indefinitely for eop.

## Test plan
- Single source: i_req = 3'b001 with ready; source sends a 3-beat frame; i_eth_rdy = 1 → o_sync[0] one cycle, 3 beats out with sop on beat 1 and eop on beat 3, 2 gap cycles, o_busy falls.
- Round-robin: i_req = 3'b111 held, each source sends 2 beats → grants in order 0, 1, 2, 0; no beat from an ungranted source reaches o_eth_*.
- Backpressure: i_eth_rdy toggles 1,0,1,0 during a 4-beat frame → o_src_rdy[g] mirrors i_eth_rdy; data holds while stalled; eop accepted only on a rdy = 1 cycle.
- Gating: i_req[1] = 1 with i_src_ready[1] = 0 → no grant; i_src_ready[1] rises → o_sync[1] on the next cycle.
- Watchdog (macro on, WDT_CYCLES = 16): source stops vld after beat 1 → o_abort pulses 16 cycles after the last accepted beat; the next requester is granted after the gap.
- Reset mid-frame: assert rst during beat 2 → all outputs 0 asynchronously; after release, source 0 wins first.

Source files
------------

// File: rtl/eth_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter_if
//
// Bundle of every signal between the TX arbiter, the frame generators that
// feed it and the MAC TX FIFO it drives.
//
// Parameter:
//   NUM_SRC      number of frame generators (must match the arbiter)
//
// Signals (direction as seen from the arbiter):
//   i_req        in   per-source level request, frame pending
//   i_src_ready  in   per-source idle flag, start strobe may be sent
//   o_sync       out  per-source one-cycle start strobe
//   i_src_data   in   per-source 32-bit data, source n at [32n+31:32n]
//   i_src_sop    in   per-source start-of-packet flag
//   i_src_eop    in   per-source end-of-packet flag
//   i_src_vld    in   per-source beat valid
//   o_src_rdy    out  per-source backpressure, only the owner can see 1
//   o_eth_data   out  muxed 32-bit data to the MAC
//   o_eth_sop    out  muxed start-of-packet
//   o_eth_eop    out  muxed end-of-packet
//   o_eth_vld    out  muxed beat valid
//   i_eth_rdy    in   MAC accepts a beat when valid and ready are both 1
//   o_grant      out  one-hot current owner, 0 when idle
//   o_busy       out  arbiter is not idle
//   o_abort      out  one-cycle pulse when the watchdog kills a frame
//
// Modports:
//   master       the arbiter
//   slave        the generators plus the MAC
// -----------------------------------------------------------------------------
interface eth_tx_arbiter_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]    i_req;
    logic [NUM_SRC-1:0]    i_src_ready;
    logic [NUM_SRC-1:0]    o_sync;
    logic [32*NUM_SRC-1:0] i_src_data;
    logic [NUM_SRC-1:0]    i_src_sop;
    logic [NUM_SRC-1:0]    i_src_eop;
    logic [NUM_SRC-1:0]    i_src_vld;
    logic [NUM_SRC-1:0]    o_src_rdy;
    logic [31:0]           o_eth_data;
    logic                  o_eth_sop;
    logic                  o_eth_eop;
    logic                  o_eth_vld;
    logic                  i_eth_rdy;
    logic [NUM_SRC-1:0]    o_grant;
    logic                  o_busy;
    logic                  o_abort;

    modport master (
        input  i_req, i_src_ready, i_src_data, i_src_sop, i_src_eop,
               i_src_vld, i_eth_rdy,
        output o_sync, o_src_rdy, o_eth_data, o_eth_sop, o_eth_eop,
               o_eth_vld, o_grant, o_busy, o_abort
    );

    modport slave (
        output i_req, i_src_ready, i_src_data, i_src_sop, i_src_eop,
               i_src_vld, i_eth_rdy,
        input  o_sync, o_src_rdy, o_eth_data, o_eth_sop, o_eth_eop,
               o_eth_vld, o_grant, o_busy, o_abort
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Round-robin owner of the single 32-bit Ethernet TX stream. Generators
// (ping, ARP, UDP, ...) raise a level request; the arbiter picks one, sends
// it a one-cycle start strobe, passes its stream through to the MAC until
// the end-of-packet beat is accepted, then holds an inter-frame gap.
//
// Parameters:
//   NUM_SRC      number of generators, 2..8 (source 0 has first priority
//                after reset)
//   IFG_CYCLES   idle cycles forced after each frame, 0..15
//   WDT_CYCLES   stall limit in cycles, used only with the watchdog
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          eth_tx_arbiter_if.master, all stream/handshake signals
//
// Build option:
//   ETH_TX_ARB_WDT_EN  when defined, a frame that makes no progress for
//                      WDT_CYCLES cycles is killed with o_abort; when not
//                      defined, o_abort is constant 0 and a frame may stall
//                      forever.
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int IFG_CYCLES = 2,
    parameter int WDT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    eth_tx_arbiter_if.master  bus
);

    localparam int          IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // The gap state always lasts at least one cycle, so the counter is
    // loaded with one less than the gap length.
    localparam logic [3:0]  GAP_LOAD = (IFG_CYCLES > 0) ? 4'(IFG_CYCLES - 1) : 4'd0;

    if (NUM_SRC < 2 || NUM_SRC > 8 || IFG_CYCLES < 0 || IFG_CYCLES > 15 ||
        WDT_CYCLES < 2) begin : g_bad_param
        $error("eth_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_XFER,
        S_GAP
    } state_t;

    state_t             state,   state_nxt;
    logic [NUM_SRC-1:0] grant,   grant_nxt;
    logic [IDX_W-1:0]   gidx,    gidx_nxt;
    logic [IDX_W-1:0]   ptr,     ptr_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;

    logic [NUM_SRC-1:0] eligible;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;

    logic [31:0]        sel_data;
    logic               sel_sop;
    logic               sel_eop;
    logic               sel_vld;

    logic               wdt_hit;

    // -------------------------------------------------------------------------
    // Round-robin pick: first eligible source searching upward from ptr+1.
    // cand is one bit wider than an index so ptr+k never wraps before the
    // explicit modulo-NUM_SRC correction.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        eligible   = bus.i_req & bus.i_src_ready;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (!pick_found && eligible[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stream mux from the granted source (used only in XFER).
    // -------------------------------------------------------------------------
    always_comb begin
        sel_data = '0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_vld  = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (gidx == IDX_W'(n)) begin
                sel_data = bus.i_src_data[n*32 +: 32];
                sel_sop  = bus.i_src_sop[n];
                sel_eop  = bus.i_src_eop[n];
                sel_vld  = bus.i_src_vld[n];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional stall watchdog. The counter restarts on every accepted beat;
    // when it reaches WDT_CYCLES-1 the frame is killed in that same cycle,
    // with valid/ready to both sides suppressed so no beat slips through.
    // -------------------------------------------------------------------------
`ifdef ETH_TX_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_hit = (state == S_XFER) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (state != S_XFER) begin
            wdt_cnt <= '0;
        end else if (bus.o_eth_vld && bus.i_eth_rdy) begin
            wdt_cnt <= '0;
        end else if (!wdt_hit) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    assign wdt_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            gidx    <= '0;
            ptr     <= IDX_W'(NUM_SRC - 1);
            gap_cnt <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state   <= state_nxt;
            grant   <= grant_nxt;
            gidx    <= gidx_nxt;
            ptr     <= ptr_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. Everything outside XFER drives a quiet bus.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        gidx_nxt        = gidx;
        ptr_nxt         = ptr;
        gap_cnt_nxt     = gap_cnt;

        bus.o_sync      = '0;
        bus.o_src_rdy   = '0;
        bus.o_eth_data  = '0;
        bus.o_eth_sop   = 1'b0;
        bus.o_eth_eop   = 1'b0;
        bus.o_eth_vld   = 1'b0;
        bus.o_grant     = grant;
        bus.o_busy      = (state != S_IDLE);
        bus.o_abort     = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt = NUM_SRC'(1) << pick_idx;
                    gidx_nxt  = pick_idx;
                    state_nxt = S_SYNC;
                end
            end

            S_SYNC: begin
                bus.o_sync = grant;
                state_nxt  = S_XFER;
            end

            S_XFER: begin
                if (wdt_hit) begin
                    bus.o_abort = 1'b1;
                    ptr_nxt     = gidx;
                    grant_nxt   = '0;
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = S_GAP;
                end else begin
                    bus.o_eth_data = sel_data;
                    bus.o_eth_sop  = sel_sop;
                    bus.o_eth_eop  = sel_eop;
                    bus.o_eth_vld  = sel_vld;
                    bus.o_src_rdy  = grant & {NUM_SRC{bus.i_eth_rdy}};
                    // Only an accepted eop ends the frame; sop is never
                    // inspected.
                    if (sel_vld && bus.i_eth_rdy && sel_eop) begin
                        ptr_nxt     = gidx;
                        grant_nxt   = '0;
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
//
// Self-checking bench for eth_tx_arbiter. Per-source generator models feed
// frames; a round-robin reference model computes the expected grant order
// and beat stream up front and pushes it into scoreboard queues. A monitor
// running on the falling edge pops and compares every start strobe and every
// accepted MAC beat, and checks bus quietness, backpressure routing, stall
// hold and inter-frame spacing.
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;

    localparam int N   = 3;
    localparam int IFG = 2;
    localparam int WDT = 16;

    typedef struct {
        int len;
        int id;
        bit stall;
    } frame_t;

    typedef struct {
        int          src;
        logic [31:0] data;
        bit          sop;
        bit          eop;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eth_tx_arbiter_if #(.NUM_SRC(N)) bus ();

    eth_tx_arbiter #(
        .NUM_SRC    (N),
        .IFG_CYCLES (IFG),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    frame_t src_q  [N][$];
    frame_t plan   [N][$];
    beat_t  exp_beats[$];
    int     exp_sync[$];
    int     exp_aborts = 0;

    int     mptr;
    int     next_id = 1;
    logic [N-1:0] hold_mask;
    int     rdy_mode;
    int     vld_pct;

    bit     active [N];
    int     beat   [N];
    bit     vld_r  [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input int s, input int id, input int b);
        return (32'(s) << 24) | ((32'(id) & 32'hff) << 16) | (32'(b) & 32'hffff);
    endfunction

    function automatic logic [63:0] outs_vec();
        return {bus.o_abort, bus.o_busy, bus.o_grant, bus.o_sync, bus.o_src_rdy,
                bus.o_eth_vld, bus.o_eth_sop, bus.o_eth_eop, bus.o_eth_data};
    endfunction

    function automatic bit all_src_empty();
        for (int s = 0; s < N; s++) if (src_q[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Generator models + MAC ready. Handshakes are sampled on the falling
    // edge, new input values are driven just after the rising edge.
    // ------------------------------------------------------------------
    initial begin : driver
        logic [N-1:0] s_sync, s_rdy, s_vld, s_grant;
        logic         s_abort;
        bit           tgl;
        tgl = 1'b0;
        bus.i_req = '0; bus.i_src_ready = '0; bus.i_src_data = '0;
        bus.i_src_sop = '0; bus.i_src_eop = '0; bus.i_src_vld = '0;
        bus.i_eth_rdy = 1'b0;
        forever begin
            @(negedge clk);
            s_sync = bus.o_sync; s_rdy = bus.o_src_rdy; s_vld = bus.i_src_vld;
            s_grant = bus.o_grant; s_abort = bus.o_abort;
            @(posedge clk);
            #1;
            tgl = ~tgl;
            for (int n = 0; n < N; n++) begin
                if (rst) begin
                    active[n] = 1'b0;
                    vld_r[n]  = 1'b0;
                end else if (active[n]) begin
                    if (s_vld[n] && s_rdy[n]) begin
                        beat[n]++;
                        vld_r[n] = 1'b0;
                        if (beat[n] == src_q[n][0].len) begin
                            active[n] = 1'b0;
                            src_q[n].delete(0);
                        end
                    end else if (s_abort && s_grant[n]) begin
                        active[n] = 1'b0;
                        vld_r[n]  = 1'b0;
                        src_q[n].delete(0);
                    end
                end else if (s_sync[n]) begin
                    active[n] = 1'b1;
                    beat[n]   = 0;
                    vld_r[n]  = 1'b0;
                end
                if (active[n]) begin
                    // Once a beat is offered it is held until accepted.
                    if (!vld_r[n])
                        vld_r[n] = ($urandom_range(99) < vld_pct) &&
                                   !(src_q[n][0].stall && beat[n] >= 1);
                    bus.i_src_vld[n] = vld_r[n];
                    bus.i_src_data[n*32 +: 32] = beat_data(n, src_q[n][0].id, beat[n]);
                    bus.i_src_sop[n] = (beat[n] == 0);
                    bus.i_src_eop[n] = (beat[n] == src_q[n][0].len - 1);
                end else begin
                    // Idle sources babble; none of it may reach the MAC.
                    bus.i_src_vld[n] = 1'($urandom_range(1));
                    bus.i_src_data[n*32 +: 32] = $urandom;
                    bus.i_src_sop[n] = 1'($urandom_range(1));
                    bus.i_src_eop[n] = 1'($urandom_range(1));
                end
                bus.i_req[n]       = !rst && (src_q[n].size() != 0);
                bus.i_src_ready[n] = !rst && !active[n] && !hold_mask[n];
            end
            case (rdy_mode)
                1:       bus.i_eth_rdy = 1'b1;
                2:       bus.i_eth_rdy = tgl;
                default: bus.i_eth_rdy = ($urandom_range(99) < 70);
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard.
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          end_cyc = 0;
    int          last_acc_cyc = 0;
    bit          gap_chk = 1'b0;
    bit          busy_chk = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_data;

    initial begin : monitor
        beat_t b;
        int    e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stalled_prev = 1'b0; gap_chk = 1'b0; busy_chk = 1'b0;
                continue;
            end
            check("rdy_only_granted", bus.o_src_rdy & ~bus.o_grant, '0);
            if (!bus.o_busy) begin
                check("idle_quiet", outs_vec(), '0);
                if (busy_chk) begin
                    check("busy_fall", 64'(cyc - end_cyc), 64'(((IFG > 0) ? IFG : 1) + 1));
                    busy_chk = 1'b0;
                end
            end
            if (bus.o_sync != '0) begin
                if (exp_sync.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sync_unexpected: got %0b expected none", bus.o_sync);
                end else begin
                    e = exp_sync.pop_front();
                    check("sync_src", bus.o_sync, N'(1) << e);
                    check("sync_grant", bus.o_grant, N'(1) << e);
                    if (gap_chk) check("frame_gap", 64'(cyc - end_cyc), 64'(IFG + 2));
                    gap_chk = 1'b0;
                end
            end
            if (stalled_prev)
                check("stall_hold", {bus.o_eth_vld, bus.o_eth_data}, {1'b1, held_data});
            stalled_prev = bus.o_eth_vld && !bus.i_eth_rdy;
            held_data    = bus.o_eth_data;
            if (bus.o_eth_vld)
                check("src_rdy_mirror", bus.o_src_rdy, bus.o_grant & {N{bus.i_eth_rdy}});
            if (bus.o_eth_vld && bus.i_eth_rdy) begin
                last_acc_cyc = cyc;
                if (exp_beats.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_unexpected: got %0h expected none", bus.o_eth_data);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_data", bus.o_eth_data, b.data);
                    check("beat_flags", {bus.o_eth_sop, bus.o_eth_eop}, {b.sop, b.eop});
                    check("beat_owner", bus.o_grant, N'(1) << b.src);
                    if (bus.o_eth_eop) begin
                        end_cyc  = cyc;
                        gap_chk  = (exp_sync.size() != 0);
                        busy_chk = 1'b1;
                    end
                end
            end
            if (bus.o_abort) begin
                check("abort_expected", 64'(exp_aborts > 0), 64'd1);
                check("abort_delay", 64'(cyc - last_acc_cyc), 64'(WDT));
                if (exp_aborts > 0) exp_aborts--;
                end_cyc  = cyc;
                gap_chk  = (exp_sync.size() != 0);
                busy_chk = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model and stimulus helpers.
    // ------------------------------------------------------------------
    task automatic add_frames(input int s, input int cnt, input int lmin, input int lmax,
                              input bit stall);
        frame_t f;
        for (int i = 0; i < cnt; i++) begin
            f.len   = $urandom_range(lmax, lmin);
            f.id    = next_id++;
            f.stall = stall;
            plan[s].push_back(f);
        end
    endtask

    // Round-robin over everything planned: next owner is the first source
    // after the previous owner that still has frames left.
    task automatic issue();
        int     pos [N];
        int     c;
        bit     found;
        frame_t f;
        beat_t  b;
        @(posedge clk);
        #2;
        for (int s = 0; s < N; s++) pos[s] = 0;
        do begin
            found = 1'b0;
            for (int k = 1; k <= N && !found; k++) begin
                c = (mptr + k) % N;
                if (pos[c] < plan[c].size()) begin
                    found = 1'b1;
                    f = plan[c][pos[c]];
                    pos[c]++;
                    exp_sync.push_back(c);
                    for (int i = 0; i < (f.stall ? 1 : f.len); i++) begin
                        b.src = c; b.data = beat_data(c, f.id, i);
                        b.sop = (i == 0); b.eop = (i == f.len - 1);
                        exp_beats.push_back(b);
                    end
                    if (f.stall) exp_aborts++;
                    mptr = c;
                end
            end
        end while (found);
        for (int s = 0; s < N; s++) begin
            foreach (plan[s][i]) src_q[s].push_back(plan[s][i]);
            plan[s].delete();
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 4000 && !(exp_beats.size() == 0 && exp_sync.size() == 0 &&
                                 all_src_empty() && !bus.o_busy));
        check({name, "_complete"}, 64'(n < 4000), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence.
    // ------------------------------------------------------------------
    initial begin : main
        int n;
        rst = 1'b1; hold_mask = '0; rdy_mode = 1; vld_pct = 100; mptr = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs_vec(), '0);
        rst = 1'b0;

        // Single source, 3 beats, MAC always ready.
        add_frames(0, 1, 3, 3, 1'b0);
        issue();
        wait_done("single");

        // All sources requesting, two 2-beat frames each.
        for (int s = 0; s < N; s++) add_frames(s, 2, 2, 2, 1'b0);
        issue();
        wait_done("round_robin");

        // Alternating MAC ready during a 4-beat frame.
        rdy_mode = 2;
        add_frames(2, 1, 4, 4, 1'b0);
        issue();
        wait_done("backpressure");
        rdy_mode = 1;

        // Request without ready must not be granted.
        hold_mask = 3'b010;
        add_frames(1, 1, 2, 2, 1'b0);
        issue();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("gate_no_grant", {bus.o_busy, bus.o_grant}, '0);
        @(posedge clk);
        #2 hold_mask = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("gate_sync_next", bus.o_sync, 3'b010);
        wait_done("gating");

`ifdef ETH_TX_ARB_WDT_EN
        // Source 0 goes silent after its first beat; source 1 waits behind.
        add_frames(0, 1, 4, 4, 1'b1);
        add_frames(1, 1, 2, 2, 1'b0);
        issue();
        wait_done("watchdog");
        check("watchdog_aborts_left", 64'(exp_aborts), 64'd0);
`endif

        // Randomized traffic.
        rdy_mode = 0; vld_pct = 75;
        for (int p = 0; p < 30; p++) begin
            for (int s = 0; s < N; s++) add_frames(s, $urandom_range(2), 1, 6, 1'b0);
            issue();
            wait_done("random");
        end

        // Reset in the middle of a frame.
        rdy_mode = 1; vld_pct = 100;
        add_frames(1, 1, 4, 4, 1'b0);
        issue();
        n = 0;
        while (exp_beats.size() > 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midframe_first_beat", 64'(n < 200), 64'd1);
        @(negedge clk);
        check("midframe_beat2_on_bus", {bus.o_eth_vld, bus.o_eth_data},
              {1'b1, beat_data(1, next_id - 1, 1)});
        #1 rst = 1'b1;
        #1 check("midframe_reset_outputs", outs_vec(), '0);
        exp_beats.delete(); exp_sync.delete();
        for (int s = 0; s < N; s++) src_q[s].delete();
        mptr = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < N; s++) add_frames(s, 1, 2, 3, 1'b0);
        issue();
        wait_done("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
